// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake.
// Register stages sit at evenly spread tree levels, or all at the output when OUT_REG_ONLY=1.
module bk_adder_pipe #(
    parameter int WIDTH        = 12,
    parameter int PIPE_STAGES  = 2,
    parameter int OUT_REG_ONLY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int LOG = $clog2(WIDTH);
    localparam int N   = 1 << LOG;
    localparam int L   = 2 * LOG + 1;

    // hp keeps the per-bit half sum, since p is overwritten by group propagates in the tree
    typedef struct packed {
        logic [N-1:0]     g;
        logic [N-1:0]     p;
        logic [WIDTH-1:0] hp;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } node_t;

    function automatic bit reg_after(input int lvl);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= PIPE_STAGES; k++) begin
            if ((k * L) / PIPE_STAGES == lvl) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic  stall;
    node_t bnd [1:L];
    logic  vld [0:L];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign vld[0]   = in_valid;

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        node_t lvl_d;

        if (j == 1) begin : g_gp
            logic [WIDTH-1:0] b_x;
            logic             c0;

            assign b_x = in_sub ? ~in_b : in_b;
            assign c0  = in_sub ? ~in_cin : in_cin;

            // carry-in folded into bit 0 so every prefix g is the carry out of its bit
            always_comb begin
                lvl_d                = '0;
                lvl_d.g[WIDTH-1:0]   = in_a & b_x;
                lvl_d.g[0]           = (in_a[0] & b_x[0]) | ((in_a[0] ^ b_x[0]) & c0);
                lvl_d.p[WIDTH-1:0]   = in_a ^ b_x;
                lvl_d.hp             = in_a ^ b_x;
                lvl_d.c0             = c0;
                lvl_d.a_msb          = in_a[WIDTH-1];
                lvl_d.b_msb          = b_x[WIDTH-1];
            end
        end else if (j <= LOG + 1) begin : g_up
            localparam int SPAN = 1 << (j - 1);
            localparam int HALF = SPAN / 2;
            node_t        x;
            logic [N-1:0] g_n;
            logic [N-1:0] p_n;

            assign x = bnd[j-1];

            for (genvar i = 0; i < N; i++) begin : g_bit
                if ((i + 1) % SPAN == 0) begin : g_op
                    assign g_n[i] = x.g[i] | (x.p[i] & x.g[i-HALF]);
                    assign p_n[i] = x.p[i] & x.p[i-HALF];
                end else begin : g_pass
                    assign g_n[i] = x.g[i];
                    assign p_n[i] = x.p[i];
                end
            end

            always_comb begin
                lvl_d   = x;
                lvl_d.g = g_n;
                lvl_d.p = p_n;
            end
        end else if (j < L) begin : g_down
            localparam int SPAN = N >> (j - LOG - 1);
            localparam int HALF = SPAN / 2;
            node_t        x;
            logic [N-1:0] g_n;
            logic [N-1:0] p_n;

            assign x = bnd[j-1];

            for (genvar i = 0; i < N; i++) begin : g_bit
                if (((i + 1) % SPAN == HALF) && (i >= SPAN)) begin : g_op
                    assign g_n[i] = x.g[i] | (x.p[i] & x.g[i-HALF]);
                    assign p_n[i] = x.p[i] & x.p[i-HALF];
                end else begin : g_pass
                    assign g_n[i] = x.g[i];
                    assign p_n[i] = x.p[i];
                end
            end

            always_comb begin
                lvl_d   = x;
                lvl_d.g = g_n;
                lvl_d.p = p_n;
            end
        end else begin : g_xor
            node_t            x;
            logic [WIDTH-1:0] carry;
            logic [WIDTH-1:0] sum_n;

            assign x     = bnd[j-1];
            assign carry = {x.g[WIDTH-2:0], x.c0};
            assign sum_n = x.hp ^ carry;

            always_comb begin
                lvl_d      = x;
                lvl_d.sum  = sum_n;
                lvl_d.cout = x.g[WIDTH-1];
                lvl_d.ovf  = (x.a_msb == x.b_msb) && (sum_n[WIDTH-1] != x.a_msb);
            end
        end

        if ((OUT_REG_ONLY == 0) && reg_after(j)) begin : g_reg
            node_t stage_q;
            logic  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    stage_q <= lvl_d;
                    valid_q <= vld[j-1];
                end
            end

            assign bnd[j] = stage_q;
            assign vld[j] = valid_q;
        end else begin : g_comb
            assign bnd[j] = lvl_d;
            assign vld[j] = vld[j-1];
        end
    end

    if (OUT_REG_ONLY != 0) begin : g_tail
        node_t tail   [0:PIPE_STAGES];
        logic  tail_v [0:PIPE_STAGES];

        assign tail[0]   = bnd[L];
        assign tail_v[0] = vld[L];

        for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stage
            node_t stage_q;
            logic  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    stage_q <= tail[k-1];
                    valid_q <= tail_v[k-1];
                end
            end

            assign tail[k]   = stage_q;
            assign tail_v[k] = valid_q;
        end

        assign out_valid = tail_v[PIPE_STAGES];
        assign out_sum   = tail[PIPE_STAGES].sum;
        assign out_cout  = tail[PIPE_STAGES].cout;
        assign out_ovf   = tail[PIPE_STAGES].ovf;
    end else begin : g_direct
        assign out_valid = vld[L];
        assign out_sum   = bnd[L].sum;
        assign out_cout  = bnd[L].cout;
        assign out_ovf   = bnd[L].ovf;
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: four configurations driven in parallel, each checked by a
// queue-based scoreboard and an arithmetic reference model.
module tb_bk_adder_pipe;
    localparam int ND = 4;
    localparam int WD [ND] = '{12, 33, 16, 2};
    localparam int PD [ND] = '{2, 13, 3, 1};

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        int unsigned adv;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_cin;
    logic        in_sub;
    logic        out_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;

    logic [11:0] s0;
    logic [32:0] s1;
    logic [15:0] s2;
    logic [1:0]  s3;
    logic        ov [ND];
    logic        co [ND];
    logic        of [ND];
    logic        ir [ND];
    logic [63:0] osum [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign osum[0] = {52'd0, s0};
    assign osum[1] = {31'd0, s1};
    assign osum[2] = {48'd0, s2};
    assign osum[3] = {62'd0, s3};

    bk_adder_pipe #(.WIDTH(12), .PIPE_STAGES(2), .OUT_REG_ONLY(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_a(in_a[11:0]), .in_b(in_b[11:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s0), .out_cout(co[0]), .out_ovf(of[0]));

    bk_adder_pipe #(.WIDTH(33), .PIPE_STAGES(13), .OUT_REG_ONLY(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_a(in_a[32:0]), .in_b(in_b[32:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s1), .out_cout(co[1]), .out_ovf(of[1]));

    bk_adder_pipe #(.WIDTH(16), .PIPE_STAGES(3), .OUT_REG_ONLY(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s2), .out_cout(co[2]), .out_ovf(of[2]));

    bk_adder_pipe #(.WIDTH(2), .PIPE_STAGES(1), .OUT_REG_ONLY(0)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .in_a(in_a[1:0]), .in_b(in_b[1:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov[3]), .out_ready(out_ready), .out_sum(s3), .out_cout(co[3]), .out_ovf(of[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
        longint mask, ua, ub, ci, r, sa, sb, sr, half;
        logic [63:0] sum;
        logic cout, ovf;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        ci   = cin ? 1 : 0;
        r    = sub ? (ua - ub - ci) : (ua + ub + ci);
        sum  = 64'(r & mask);
        cout = sub ? (ua >= ub + ci) : (r > mask);
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        sr   = sub ? (sa - sb - ci) : (sa + sb + ci);
        ovf  = (sr < -half) || (sr >= half);
        return {ovf, cout, sum};
    endfunction

    beat_t       sbq [ND][$];
    int unsigned adv [ND];
    logic        post_rst [ND];
    logic        was_stall [ND];
    logic [63:0] prev_sum [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            adv[d] = 0;
            post_rst[d] = 1'b0;
            was_stall[d] = 1'b0;
            prev_sum[d] = '0;
        end
    end

    // Scoreboard per instance: a beat must surface after exactly PD advancing edges.
    always @(negedge clk) begin
        logic        exp_v;
        logic [65:0] r;
        beat_t       h;
        beat_t       nb;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                sbq[d].delete();
                post_rst[d]  = 1'b1;
                was_stall[d] = 1'b0;
            end else begin
                exp_v = (sbq[d].size() > 0) && (adv[d] - sbq[d][0].adv == PD[d]);
                check($sformatf("d%0d_out_valid", d), 64'(ov[d]), 64'(exp_v));
                check($sformatf("d%0d_in_ready", d), 64'(ir[d]), 64'(!(exp_v && !out_ready)));
                if (post_rst[d]) begin
                    check($sformatf("d%0d_rst_sum", d), osum[d], 64'd0);
                    check($sformatf("d%0d_rst_cout", d), 64'(co[d]), 64'd0);
                    check($sformatf("d%0d_rst_ovf", d), 64'(of[d]), 64'd0);
                    post_rst[d] = 1'b0;
                end
                if (exp_v) begin
                    h = sbq[d][0];
                    r = ref_add(WD[d], h.a, h.b, h.cin, h.sub);
                    check($sformatf("d%0d_sum", d), osum[d], r[63:0]);
                    check($sformatf("d%0d_cout", d), 64'(co[d]), 64'(r[64]));
                    check($sformatf("d%0d_ovf", d), 64'(of[d]), 64'(r[65]));
                end
                if (was_stall[d]) begin
                    check($sformatf("d%0d_stall_hold", d), osum[d], prev_sum[d]);
                end
                was_stall[d] = exp_v && !out_ready;
                prev_sum[d]  = osum[d];
                if (exp_v && out_ready) begin
                    void'(sbq[d].pop_front());
                end
                if (in_valid && ir[d]) begin
                    nb.a = in_a;
                    nb.b = in_b;
                    nb.cin = in_cin;
                    nb.sub = in_sub;
                    nb.adv = adv[d];
                    sbq[d].push_back(nb);
                end
                if (!(exp_v && !out_ready)) begin
                    adv[d]++;
                end
            end
        end
    end

    task automatic new_beat();
        in_a   = {$urandom, $urandom};
        in_b   = {$urandom, $urandom};
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: in_a = '1;
            1: in_b = '1;
            2: in_b = in_a;
            default: ;
        endcase
    endtask

    // Called at posedge+1; one beat into an idle-ready pipe, result read from instance 0.
    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub,
                            input logic [11:0] es, input logic ec, input logic eo);
        int n;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(PD[0] - 1));
        check({tag, "_sum"}, osum[0], {52'd0, es});
        check({tag, "_cout"}, 64'(co[0]), 64'(ec));
        check({tag, "_ovf"}, 64'(of[0]), 64'(eo));
    endtask

    initial begin
        int   sent;
        int   cyc;
        logic acc;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(ov[0]), 64'd0);
        check("reset_in_ready", 64'(ir[0]), 64'd1);
        check("reset_sum", osum[0], 64'd0);
        rst = 1'b0;

        directed("add_wrap", 64'hFFF, 64'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        directed("add_ovf",  64'h7FF, 64'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
        directed("sub_ovf",  64'h800, 64'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
        directed("sub_borrow", 64'h005, 64'h007, 1'b1, 1'b1, 12'hFFD, 1'b0, 1'b0);
        directed("sub_equal", 64'h123, 64'h123, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0);

        // two beats in flight, then reset with a beat presented
        out_ready = 1'b1;
        in_valid = 1'b1;
        new_beat();
        @(posedge clk);
        #1 new_beat();
        @(posedge clk);
        #1 new_beat();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(ov[0]), 64'd0);
        check("flush_in_ready", 64'(ir[0]), 64'd1);
        check("flush_sum", osum[0], 64'd0);
        check("flush_cout", 64'(co[0]), 64'd0);
        check("flush_ovf", 64'(of[0]), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1 check("flush_no_accept", 64'(ov[0]), 64'd0);
        end

        // 100-beat stream with a 3-cycle output stall in the middle
        sent = 0;
        cyc = 0;
        new_beat();
        while (sent < 100 && cyc < 2000) begin
            out_ready = !(cyc >= 40 && cyc < 43);
            in_valid = 1'b1;
            @(negedge clk);
            acc = ir[0];
            if (cyc >= 40 && cyc <= 43) begin
                check("stream_stall_in_ready", 64'(ir[0]), 64'(cyc == 43));
            end
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                new_beat();
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'd100);
        repeat (30) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_stream_drained", d), 64'(sbq[d].size()), 64'd0);
        end

        // random traffic and backpressure, with a reset pulse midway
        acc = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 8);
                new_beat();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst = (c == 3000);
            @(negedge clk);
            acc = ir[0] && in_valid && !rst;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_random_drained", d), 64'(sbq[d].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
